// File: rtl/stopwatch_time_core_pkg.sv
// Shared definitions for the stopwatch time core and the display controller.
// Holds the time-word field widths, legal maxima, bit offsets inside the
// packed 24-bit word {hour, min, sec, msec}, the control FSM encoding, and the
// wrap-increment helper used by every field counter.
package stopwatch_time_core_pkg;

  // Field widths of the packed time word
  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DATA_W = MSEC_W + SEC_W + MIN_W + HOUR_W;

  // Field LSB positions inside the packed word (shared with the display side)
  localparam int MSEC_LSB = 0;
  localparam int SEC_LSB  = MSEC_LSB + MSEC_W;
  localparam int MIN_LSB  = SEC_LSB + SEC_W;
  localparam int HOUR_LSB = MIN_LSB + MIN_W;

  // Largest legal value of each field, held at the common 7-bit helper width
  localparam logic [6:0] MSEC_MAX = 7'd99;
  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd23;

  // Control FSM encoding
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // +1 with wrap to 0 at max_value. Anything at or above the maximum also
  // returns 0, so a field can never be pushed out of its legal range.
  function automatic logic [6:0] inc_wrap(input logic [6:0] value,
                                          input logic [6:0] max_value);
    logic [6:0] result;
    if (value >= max_value) begin
      result = 7'd0;
    end else begin
      result = value + 7'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stopwatch_time_core_tick_gen.sv
// tick_gen: prescaler that divides clk down to a periodic 1-cycle tick.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset (0 = reset)
//   en    - count enable; the counter holds its value while low
//   clr   - synchronous clear of the counter (wins over en)
//   tick  - combinational tick condition: en high and counter at TICK_DIV-1
// The counter wraps to 0 on the same edge that the tick is consumed.
module tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             at_last_s;

  assign at_last_s = (cnt_r == LAST);
  assign tick      = en & ~clr & at_last_s;

  // Prescaler: clear, count with wrap while enabled, otherwise hold the phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (at_last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/stopwatch_time_core.sv
// stopwatch_time_core: 1/100 s stopwatch feeding the 7-segment display stage.
// Ports:
//   clk        - system clock (100 MHz)
//   reset      - asynchronous active-low reset (0 = reset)
//   i_run_stop - 1-cycle pulse, toggles run/stop
//   i_clear    - 1-cycle pulse, zeroes the time while stopped
//   i_inc_sec  - 1-cycle pulse, sec+1 (wrap, no carry) while stopped
//   i_inc_min  - 1-cycle pulse, min+1 (wrap, no carry) while stopped
//   i_inc_hour - 1-cycle pulse, hour+1 (wrap) while stopped
//   o_data     - registered {hour[23:19], min[18:13], sec[12:7], msec[6:0]}
//   o_running  - high while the FSM is in RUN
//   o_tick     - registered 1-cycle pulse, aligned with the o_data update
module stopwatch_time_core
  import stopwatch_time_core_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run_stop,
  input  logic              i_clear,
  input  logic              i_inc_sec,
  input  logic              i_inc_min,
  input  logic              i_inc_hour,
  output logic [DATA_W-1:0] o_data,
  output logic              o_running,
  output logic              o_tick
);

  state_e              state_r;
  state_e              next_state_s;
  logic [MSEC_W-1:0]   msec_r, msec_s;
  logic [SEC_W-1:0]    sec_r,  sec_s;
  logic [MIN_W-1:0]    min_r,  min_s;
  logic [HOUR_W-1:0]   hour_r, hour_s;
  logic                tick_s;
  logic                tick_r;
  logic                running_r;
  logic                run_en_s;
  logic                clr_en_s;

  assign run_en_s = (state_r == ST_RUN);
  assign clr_en_s = (state_r == ST_CLEAR);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (run_en_s),
    .clr   (clr_en_s),
    .tick  (tick_s)
  );

  // Next-state logic: clear beats run/stop in STOP, clear is ignored in RUN
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_STOP: begin
        if (i_clear) begin
          next_state_s = ST_CLEAR;
        end else if (i_run_stop) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      ST_RUN: begin
        if (i_run_stop) begin
          next_state_s = ST_STOP;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_CLEAR: next_state_s = ST_STOP;
      default:  next_state_s = ST_STOP;
    endcase
  end

  // Field next values: cascaded tick carry in RUN, independent set pulses in
  // STOP, zero in CLEAR. A tick coinciding with run/stop is still applied.
  always_comb begin
    msec_s = msec_r;
    sec_s  = sec_r;
    min_s  = min_r;
    hour_s = hour_r;
    case (state_r)
      ST_RUN: begin
        if (tick_s) begin
          msec_s = MSEC_W'(inc_wrap(msec_r, MSEC_MAX));
          if (msec_r >= MSEC_MAX) begin
            sec_s = SEC_W'(inc_wrap({1'b0, sec_r}, SEC_MAX));
            if ({1'b0, sec_r} >= SEC_MAX) begin
              min_s = MIN_W'(inc_wrap({1'b0, min_r}, MIN_MAX));
              if ({1'b0, min_r} >= MIN_MAX) begin
                hour_s = HOUR_W'(inc_wrap({2'b00, hour_r}, HOUR_MAX));
              end else begin
                hour_s = hour_r;
              end
            end else begin
              min_s = min_r;
            end
          end else begin
            sec_s = sec_r;
          end
        end else begin
          msec_s = msec_r;
        end
      end
      ST_STOP: begin
        if (i_inc_sec) begin
          sec_s = SEC_W'(inc_wrap({1'b0, sec_r}, SEC_MAX));
        end else begin
          sec_s = sec_r;
        end
        if (i_inc_min) begin
          min_s = MIN_W'(inc_wrap({1'b0, min_r}, MIN_MAX));
        end else begin
          min_s = min_r;
        end
        if (i_inc_hour) begin
          hour_s = HOUR_W'(inc_wrap({2'b00, hour_r}, HOUR_MAX));
        end else begin
          hour_s = hour_r;
        end
      end
      ST_CLEAR: begin
        msec_s = '0;
        sec_s  = '0;
        min_s  = '0;
        hour_s = '0;
      end
      default: begin
        msec_s = '0;
        sec_s  = '0;
        min_s  = '0;
        hour_s = '0;
      end
    endcase
  end

  // State, time fields and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_STOP;
      msec_r    <= '0;
      sec_r     <= '0;
      min_r     <= '0;
      hour_r    <= '0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      msec_r    <= msec_s;
      sec_r     <= sec_s;
      min_r     <= min_s;
      hour_r    <= hour_s;
      tick_r    <= tick_s;
      running_r <= (next_state_s == ST_RUN);
    end
  end

  assign o_data    = {hour_r, min_r, sec_r, msec_r};
  assign o_running = running_r;
  assign o_tick    = tick_r;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Directed bench for stopwatch_time_core with TICK_DIV=4: a vector table for
// the control/set/run interplay plus hand-written long-run and reset sequences.
module tb_stopwatch_time_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_run_stop = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_inc_sec = 1'b0;
  logic        i_inc_min = 1'b0;
  logic        i_inc_hour = 1'b0;
  logic [23:0] o_data;
  logic        o_running;
  logic        o_tick;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rs;
    logic        clr;
    logic        is;
    logic        im;
    logic        ih;
    logic [23:0] d;
    logic        run;
    logic        tck;
  } vec_t;

  vec_t vq[$];

  stopwatch_time_core #(
    .TICK_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_run_stop (i_run_stop),
    .i_clear    (i_clear),
    .i_inc_sec  (i_inc_sec),
    .i_inc_min  (i_inc_min),
    .i_inc_hour (i_inc_hour),
    .o_data     (o_data),
    .o_running  (o_running),
    .o_tick     (o_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive inputs for one cycle, return at next posedge+1.
  task automatic step(input logic rs, input logic clr, input logic is,
                      input logic im, input logic ih);
    i_run_stop = rs;
    i_clear    = clr;
    i_inc_sec  = is;
    i_inc_min  = im;
    i_inc_hour = ih;
    @(posedge clk);
    #1;
    i_run_stop = 1'b0;
    i_clear    = 1'b0;
    i_inc_sec  = 1'b0;
    i_inc_min  = 1'b0;
    i_inc_hour = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic [4:0] in_bits, input logic [23:0] d,
                              input logic run, input logic tck);
    vec_t v;
    v.rs  = in_bits[4];
    v.clr = in_bits[3];
    v.is  = in_bits[2];
    v.im  = in_bits[1];
    v.ih  = in_bits[0];
    v.d   = d;
    v.run = run;
    v.tck = tck;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;

    // inputs as {rs, clr, is, im, ih}
    vq.push_back(mk(5'b00100, 24'h000080, 1'b0, 1'b0)); // sec+1
    vq.push_back(mk(5'b00010, 24'h002080, 1'b0, 1'b0)); // min+1
    vq.push_back(mk(5'b00001, 24'h082080, 1'b0, 1'b0)); // hour+1
    vq.push_back(mk(5'b00111, 24'h104100, 1'b0, 1'b0)); // all three at once
    vq.push_back(mk(5'b10000, 24'h104100, 1'b1, 1'b0)); // -> RUN, phase 0
    vq.push_back(mk(5'b00000, 24'h104100, 1'b1, 1'b0));
    vq.push_back(mk(5'b00000, 24'h104100, 1'b1, 1'b0));
    vq.push_back(mk(5'b00100, 24'h104100, 1'b1, 1'b0)); // inc ignored in RUN
    vq.push_back(mk(5'b01000, 24'h104101, 1'b1, 1'b1)); // clear ignored, tick
    vq.push_back(mk(5'b00000, 24'h104101, 1'b1, 1'b0));
    vq.push_back(mk(5'b10000, 24'h104101, 1'b0, 1'b0)); // stop mid-phase
    vq.push_back(mk(5'b00000, 24'h104101, 1'b0, 1'b0));
    vq.push_back(mk(5'b10000, 24'h104101, 1'b1, 1'b0)); // resume
    vq.push_back(mk(5'b00000, 24'h104101, 1'b1, 1'b0));
    vq.push_back(mk(5'b00010, 24'h104102, 1'b1, 1'b1)); // phase kept, inc ignored
    vq.push_back(mk(5'b00000, 24'h104102, 1'b1, 1'b0));
    vq.push_back(mk(5'b10000, 24'h104102, 1'b0, 1'b0)); // stop, prescaler at 2
    vq.push_back(mk(5'b11000, 24'h104102, 1'b0, 1'b0)); // clear beats run
    vq.push_back(mk(5'b10000, 24'h000000, 1'b0, 1'b0)); // CLEAR cycle, rs ignored
    vq.push_back(mk(5'b10000, 24'h000000, 1'b1, 1'b0)); // -> RUN from phase 0
    vq.push_back(mk(5'b00000, 24'h000000, 1'b1, 1'b0));
    vq.push_back(mk(5'b00000, 24'h000000, 1'b1, 1'b0));
    vq.push_back(mk(5'b00000, 24'h000000, 1'b1, 1'b0));
    vq.push_back(mk(5'b00000, 24'h000001, 1'b1, 1'b1));
    vq.push_back(mk(5'b00000, 24'h000001, 1'b1, 1'b0));
    vq.push_back(mk(5'b00000, 24'h000001, 1'b1, 1'b0));
    vq.push_back(mk(5'b00000, 24'h000001, 1'b1, 1'b0));
    vq.push_back(mk(5'b10000, 24'h000002, 1'b0, 1'b1)); // stop on tick cycle
    vq.push_back(mk(5'b00000, 24'h000002, 1'b0, 1'b0));
    vq.push_back(mk(5'b10000, 24'h000002, 1'b1, 1'b0));
    vq.push_back(mk(5'b11000, 24'h000002, 1'b0, 1'b0)); // RUN: clear ignored, stop
    vq.push_back(mk(5'b00100, 24'h000082, 1'b0, 1'b0));

    // Reset state while reset is held
    #3;
    check("reset_data", o_data, 24'h000000);
    check("reset_running", {23'd0, o_running}, 24'd0);
    check("reset_tick", {23'd0, o_tick}, 24'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Table vectors
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rs, vq[i].clr, vq[i].is, vq[i].im, vq[i].ih);
      check($sformatf("vec%0d_data", i), o_data, vq[i].d);
      check($sformatf("vec%0d_running", i), {23'd0, o_running}, {23'd0, vq[i].run});
      check($sformatf("vec%0d_tick", i), {23'd0, o_tick}, {23'd0, vq[i].tck});
    end

    // 100 ticks from zero -> 00:00:01.00
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (o_tick) ticks++;
      if (!o_running) check($sformatf("run400_running_c%0d", i), 24'd0, 24'd1);
    end
    check("run400_data", o_data, 24'h000080);
    check("run400_ticks", 24'(ticks), 24'd100);

    // Set to 23:59:59, wrap checks, then roll over the whole day
    do_reset();
    repeat (59) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (59) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (23) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("set_235959", o_data, 24'hBF7D80);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sec_wrap_no_carry", o_data, 24'hBF6000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sec_min_together", o_data, 24'hB80080);
    repeat (58) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (59) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_235959", o_data, 24'hBF7D80);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (396) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("day_end_99", o_data, 24'hBF7DE3);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("day_rollover", o_data, 24'h000000);
    check("day_rollover_tick", {23'd0, o_tick}, 24'd1);

    // Async reset mid-run at 00:00:12.34
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4936) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("at_12_34", o_data, 24'h000622);
    check("at_12_34_tick", {23'd0, o_tick}, 24'd1);
    reset = 1'b0;
    #1;
    check("async_rst_data", o_data, 24'h000000);
    check("async_rst_running", {23'd0, o_running}, 24'd0);
    check("async_rst_tick", {23'd0, o_tick}, 24'd0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (o_tick) ticks++;
    end
    check("post_rst_idle_data", o_data, 24'h000000);
    check("post_rst_idle_running", {23'd0, o_running}, 24'd0);
    check("post_rst_idle_ticks", 24'(ticks), 24'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_first_tick", o_data, 24'h000001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_core.md
Name: stopwatch_time_core

Overview:
Time-keeping datapath and control FSM that sits directly upstream of the 7-segment display controller. It produces the packed 24-bit time word {hour[4:0], min[5:0], sec[5:0], msec[6:0]} that the display stage splits into digits. It runs a stopwatch with 1/100 s resolution, with run/stop, clear and manual field-set controls. All control inputs are single-cycle pulses from the existing button-debounce and UART-command stages.

Parameters:
TICK_DIV, 1_000_000, number of clk cycles per 10 ms tick (100 MHz / 100 Hz); benches override it to 4.

Ports:
clk  input  1  system clock, 100 MHz.
reset  input  1  asynchronous, active-low reset (asserted when 0).
i_run_stop  input  1  1-cycle pulse; toggles run/stop.
i_clear  input  1  1-cycle pulse; zeroes time when stopped.
i_inc_sec  input  1  1-cycle pulse; sec+1 when stopped.
i_inc_min  input  1  1-cycle pulse; min+1 when stopped.
i_inc_hour  input  1  1-cycle pulse; hour+1 when stopped.
o_data  output  24  {hour[23:19], min[18:13], sec[12:7], msec[6:0]}, registered.
o_running  output  1  1 while the FSM is in RUN.
o_tick  output  1  1-cycle pulse on each 10 ms tick, valid only in RUN.

Behaviour:
- Reset (reset=0, async): state=STOP, prescaler=0, all fields=0, o_data=0, o_running=0, o_tick=0.
- FSM states: STOP, RUN, CLEAR.
  - STOP + i_clear -> CLEAR. i_clear has priority over i_run_stop in the same cycle.
  - STOP + i_run_stop (no clear) -> RUN.
  - RUN + i_run_stop -> STOP. i_clear in RUN is ignored, including when it arrives together with i_run_stop.
  - CLEAR lasts exactly 1 cycle: fields and prescaler are zeroed, then -> STOP unconditionally. Inputs during CLEAR are ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds its value in STOP, so a resumed run keeps the partial tick; zeroed in CLEAR.
  - The tick fires in the cycle where prescaler==TICK_DIV-1 and the state is RUN; the prescaler then wraps to 0.
  - o_tick is registered and asserts the cycle after the tick condition, aligned with the o_data update.
- Tick arithmetic (cascaded, all in the same cycle):
  - msec 0..99: 99 -> 0 carries to sec.
  - sec 0..59: 59 -> 0 carries to min.
  - min 0..59: 59 -> 0 carries to hour.
  - hour 0..23: 23 -> 0, no overflow flag.
  - Example: 23:59:59.99 -> 00:00:00.00 in one tick.
- Tick coincident with i_run_stop in RUN: the tick is applied, then the state becomes STOP. The count is not lost.
- Set increments:
  - Honoured only in STOP. Each pulse is +1 with wrap in its own field (sec 59->0, min 59->0, hour 23->0) and no carry into the next field.
  - msec is untouched by set pulses.
  - Several inc pulses in the same cycle all apply, each to its own field.
  - Ignored in RUN and in CLEAR.
- o_data changes only on a tick, a set pulse, CLEAR, or reset. Latency is 1 cycle from the causing event to o_data.
- Reset asserted mid-run: immediate async return to the reset state above; counting restarts only after a new i_run_stop.
- Field values never leave their legal range; no out-of-range value is ever presented downstream.

Decomposition:
- Shared package:
  - Field widths: MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5.
  - Limits: MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field bit offsets within the 24-bit word, also used by the display controller.
  - FSM state encoding {STOP, RUN, CLEAR}.
- Sub-module tick_gen: prescaler with enable, clear and parameter TICK_DIV; outputs a 1-cycle tick. It is reused by the watch block later.
- Field counters stay inline: four wrap-counters with carry chain.

Test Plan:
- Reset, then i_run_stop, then 400 cycles (TICK_DIV=4) -> 100 ticks; o_data = sec 1, msec 0 (0x000080); o_running=1 throughout.
- In STOP, 59 i_inc_sec pulses, 59 i_inc_min, 23 i_inc_hour -> 23:59:59.00. Run 100 ticks -> 00:00:00.00 (o_data=0) in one tick after 23:59:59.99.
- RUN, i_run_stop on the tick-condition cycle -> the msec increment is still applied and o_running=0 next cycle. A later i_run_stop resumes with the preserved prescaler phase.
- In RUN, pulse i_clear and i_inc_min -> o_data unchanged except normal ticks. In STOP, i_clear+i_run_stop in the same cycle -> CLEAR wins: o_data=0, state STOP, o_running=0.
- In STOP at sec=59, i_inc_sec -> sec=0 and min unchanged; i_inc_sec+i_inc_min together -> both fields +1.
- Drive reset low mid-run at 00:00:12.34 -> o_data=0, o_running=0, o_tick=0 immediately (async, before the next clk edge). After release, no counting until i_run_stop.
